multicycle_controller: RTL

//  Control FSM for the multi-cycle RV32I datapath; drives the 2-bit ALU (alu_control) and consumes its flags.

---
 rtl/riscv_ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package riscv_ctrl_pkg;

    // FSM state encoding
    typedef logic [3:0] state_t;
    localparam state_t StFetch    = 4'd0;
    localparam state_t StDecode   = 4'd1;
    localparam state_t StMemAdr   = 4'd2;
    localparam state_t StMemRead  = 4'd3;
    localparam state_t StMemWb    = 4'd4;
    localparam state_t StMemWrite = 4'd5;
    localparam state_t StExecR    = 4'd6;
    localparam state_t StExecI    = 4'd7;
    localparam state_t StAluWb    = 4'd8;
    localparam state_t StBranch   = 4'd9;
    localparam state_t StJal      = 4'd10;
    localparam state_t StHalt     = 4'd11;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResMemData = 2'b01;
    localparam logic [1:0] ResAlu     = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // Immediate format is a pure function of the opcode
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the controller (master) and the datapath (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_control;
    logic       halted;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, negative, overflow, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, halted, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, negative, overflow, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, halted, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU control decode: maps the FSM's ALU request plus funct fields to a 2-bit ALU op.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output alu_ctrl_t  alu_control,
    output logic       funct_illegal
);

    alu_ctrl_t funct_alu;

    // funct3 decode; sub only for R-type (op[5]=1) with funct7b5 set
    always_comb begin
        funct_alu     = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct3)
            3'b000:  funct_alu = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_illegal = 1'b1;
        endcase
    end

    // Select between fixed add/sub and the funct-decoded operation
    always_comb begin
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_alu;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (lw, sw, R/I ALU, branch, jal) with sticky halt.
// Optional macro BRANCH_EXT_EN adds bne/blt/bge on top of beq.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_controller_if.master bus
);

    // Last count value before the limit 2**TIMEOUT_W-1 is reached
    localparam logic [TIMEOUT_W-1:0] WaitLast = ~TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] WaitOne  = TIMEOUT_W'(1);

    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   wait_q, wait_d;
    logic                   halted_q, halted_d;
    logic                   illegal_q, illegal_d;

    logic       pc_write, ir_write, reg_write, mem_write, adr_src, waiting;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    alu_op_t    alu_op;
    alu_ctrl_t  alu_ctrl;
    logic       funct_illegal;
    logic       branch_ok, branch_taken;

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (bus.funct3),
        .funct7b5      (bus.funct7b5),
        .op_b5         (bus.op[5]),
        .alu_control   (alu_ctrl),
        .funct_illegal (funct_illegal)
    );

    // Branch legality and condition evaluation from funct3 and ALU flags
    always_comb begin
        branch_ok    = 1'b0;
        branch_taken = 1'b0;
        case (bus.funct3)
            3'b000: begin branch_ok = 1'b1; branch_taken = bus.zero; end
`ifdef BRANCH_EXT_EN
            3'b001: begin branch_ok = 1'b1; branch_taken = ~bus.zero; end
            3'b100: begin branch_ok = 1'b1; branch_taken = bus.negative ^ bus.overflow; end
            3'b101: begin branch_ok = 1'b1; branch_taken = ~(bus.negative ^ bus.overflow); end
`endif
            default: ;
        endcase
    end

`ifndef BRANCH_EXT_EN
    logic unused_flags;
    assign unused_flags = bus.negative ^ bus.overflow;
`endif

    // Next state, wait counter, sticky flags and per-state control outputs
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        waiting    = 1'b0;
        result_src = ResAlu;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBFour;
        alu_op     = ALUOP_ADD;
        case (state_q)
            StFetch: begin
                waiting = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:  state_d = funct_illegal ? StHalt : StExecR;
                    OpIType:  state_d = funct_illegal ? StHalt : StExecI;
                    OpBranch: state_d = branch_ok ? StBranch : StHalt;
                    OpJal:    state_d = StJal;
                    default:  state_d = StHalt;
                endcase
                illegal_d = (state_d == StHalt);
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = (bus.op == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src    = 1'b1;
                result_src = ResAluOut;
                waiting    = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResMemData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src    = 1'b1;
                result_src = ResAluOut;
                mem_write  = 1'b1;
                waiting    = 1'b1;
                if (bus.mem_ready) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = ALUOP_FUNCT;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = ALUOP_FUNCT;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBRs2;
                alu_op     = ALUOP_SUB;
                result_src = ResAluOut;
                pc_write   = branch_taken;
                state_d    = StFetch;
            end
            StJal: begin
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pc_write   = 1'b1;
                state_d    = StAluWb;
            end
            StHalt: ;
            default: state_d = StHalt;
        endcase
        // A ready in the limit cycle is not a wait cycle, so it never times out
        if (waiting && !bus.mem_ready) begin
            if (wait_q == WaitLast) begin
                state_d   = StHalt;
                illegal_d = 1'b0;
            end else begin
                wait_d = wait_q + WaitOne;
            end
        end
        if (state_d == StHalt) halted_d = 1'b1;
    end

    // State, wait counter and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are gated by rst so an access drops the instant reset rises
    assign bus.pc_write    = pc_write & ~rst;
    assign bus.ir_write    = ir_write & ~rst;
    assign bus.reg_write   = reg_write & ~rst;
    assign bus.mem_write   = mem_write & ~rst;
    assign bus.adr_src     = adr_src;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_ctrl;
    assign bus.imm_src     = imm_src_of(bus.op);
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;

endmodule
